fifo_sync: RTL and testbench
============================

FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 The block SHALL be parameterised as follows:
- DATAWIDTH, default 8: word width in bits.
- ADDRWIDTH, default 5: log2 of depth; DEPTH = 2**ADDRWIDTH entries.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, input, 1: single clock; all state updates on rising edge.
- reset_l, input, 1: reset, synchronous and active-low.
- wr_data, input, DATAWIDTH: write word.
- we, input, 1: write enable; push wr_data this cycle.
- full, output, 1: FIFO holds DEPTH words; writes not accepted.
- ns_rd_data, output, DATAWIDTH: head word, non-registered, first-word fall-through.
- re, input, 1: read enable; pop the head word this cycle.
- ns_ne, output, 1: FIFO non-empty, non-registered; ns_rd_data is valid.

Function
REQ-003 The block SHALL store words strictly in write order and return them in the same order with no loss, duplication or reordering.
REQ-004 The block SHALL accept a write on a rising edge where we=1 and full=0, storing wr_data at the write pointer and incrementing that pointer modulo DEPTH.
REQ-005 The block SHALL ignore a write where we=1 and full=1: no storage, no pointer change, no error output. This holds even if re=1 in the same cycle.
REQ-006 The block SHALL accept a read on a rising edge where re=1 and ns_ne=1, incrementing the read pointer modulo DEPTH.
REQ-007 The block SHALL ignore a read where re=1 and ns_ne=0, with no pointer change. A write in the same cycle still completes.
REQ-008 ns_rd_data SHALL equal the word at the read pointer, driven combinationally from memory and pointer state. Its value is don't-care while ns_ne=0.
REQ-009 ns_ne SHALL be derived combinationally from an occupancy count that is updated only at clock edges.
REQ-010 A word written at edge N SHALL appear on ns_rd_data/ns_ne immediately after edge N (one-cycle write-to-read latency). Two writes SHALL never bypass each other.
REQ-011 The occupancy count SHALL be ADDRWIDTH+1 bits wide and updated per edge as follows:
- +1 on an accepted write only.
- -1 on an accepted read only.
- Unchanged on both or neither.
REQ-012 full SHALL be 1 exactly when count==DEPTH. ns_ne SHALL be 1 exactly when count!=0.
REQ-013 Simultaneous accepted read and write at any count between 1 and DEPTH-1 SHALL leave count unchanged and advance both pointers.
REQ-014 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless with no bubble.
REQ-015 Outputs SHALL have no combinational path from we or re. ns_rd_data depends only on state.

Reset
REQ-016 When reset_l=0 at a rising edge, the block SHALL clear the read pointer, write pointer and count, giving ns_ne=0 and full=0 after that edge.
REQ-017 Reset SHALL take priority over simultaneous we/re. Memory contents need not be cleared.
REQ-018 Reset asserted mid-operation SHALL discard all stored words. The first write after reset deassertion SHALL be the first word read.

Structure
REQ-019 No shared package is required; DATAWIDTH and ADDRWIDTH are module parameters only.
REQ-020 Storage SHALL be a dual-port memory with synchronous write and asynchronous read, in sub-module fifo_sync_ram (parameters DATAWIDTH, ADDRWIDTH). Pointer and flag logic SHALL reside in fifo_sync.

Verification
REQ-021 The bench SHALL cover the following directed scenarios, at DATAWIDTH=64 and ADDRWIDTH=5 unless stated:
- Reset, then idle 4 cycles -> ns_ne=0, full=0.
- Write 0x1111_2222_3333_4444 with one we pulse -> next cycle ns_ne=1 and ns_rd_data=0x1111_2222_3333_4444. One re pulse -> ns_ne=0.
- Write 32 words 0..31 -> full=1 after the 32nd write. A 33rd write of 0xDEAD is dropped. Reading 32 words returns 0..31 in order, then ns_ne=0.
- Hold count at 16, then assert we and re together for 100 cycles with incrementing data -> count stays 16, full=0, ns_ne=1, read data in order across pointer wrap.
- re on empty with simultaneous we of 0x55 -> read ignored, next cycle ns_ne=1 and ns_rd_data=0x55.
- Fill with 10 words, assert reset_l=0 for one edge -> ns_ne=0. Next write 0xA5 reads back first.
- DATAWIDTH=72 instance -> the same scenarios pass, with the upper 8 bits preserved.

Source files
------------

// File: rtl/fifo_sync_pkg.sv
// Shared types for the synchronous FIFO: the per-edge occupancy operation.
package fifo_sync_pkg;

    // Bit 0 = accepted push, bit 1 = accepted pop.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_sync_ram.sv
// Dual-port storage for fifo_sync: synchronous write port, asynchronous read port.
module fifo_sync_ram #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 5
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [ADDRWIDTH-1:0] i_wr_addr,
    input  logic [DATAWIDTH-1:0] i_wr_data,
    input  logic [ADDRWIDTH-1:0] i_rd_addr,
    output logic [DATAWIDTH-1:0] o_rd_data
);

    localparam int DEPTH = 2 ** ADDRWIDTH;

    logic [DATAWIDTH-1:0] r_mem [DEPTH];

    // Store the write word on the rising edge when the write port is enabled.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read is purely combinational from the addressed entry.
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with first-word fall-through head output.
// Pointers and occupancy count live here; storage is in fifo_sync_ram.
module fifo_sync
    import fifo_sync_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic                 we,
    output logic                 full,
    output logic [DATAWIDTH-1:0] ns_rd_data,
    input  logic                 re,
    output logic                 ns_ne
);

    localparam logic [ADDRWIDTH:0] DEPTH_CNT = (ADDRWIDTH+1)'(2 ** ADDRWIDTH);

    logic [ADDRWIDTH-1:0] r_wr_ptr;
    logic [ADDRWIDTH-1:0] r_rd_ptr;
    logic [ADDRWIDTH:0]   r_count;

    logic                 w_wr_acc;
    logic                 w_rd_acc;
    fifo_op_e             w_op;
    logic [ADDRWIDTH:0]   w_count_nxt;

    // Flags depend on registered count only, so no path from we/re to outputs.
    assign full     = (r_count == DEPTH_CNT);
    assign ns_ne    = (r_count != '0);

    // A write is dropped when full and a read is dropped when empty,
    // regardless of what the other port is doing.
    assign w_wr_acc = we & ~full;
    assign w_rd_acc = re & ns_ne;

    // Classify the edge and derive the next occupancy count.
    always_comb begin
        w_op        = fifo_op_e'({w_rd_acc, w_wr_acc});
        w_count_nxt = r_count;
        case (w_op)
            OP_PUSH: w_count_nxt = r_count + 1'b1;
            OP_POP:  w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer and count registers; reset wins over any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    fifo_sync_ram #(
        .DATAWIDTH (DATAWIDTH),
        .ADDRWIDTH (ADDRWIDTH)
    ) u_ram (
        .i_clk     (clk),
        .i_we      (w_wr_acc & reset_l),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (ns_rd_data)
    );

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench: a 64-bit and a 72-bit fifo_sync driven in lockstep.
module tb_fifo_sync;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        we;
    logic        re;
    logic [71:0] wr_data;

    logic        full64, ne64, full72, ne72;
    logic [63:0] rd64;
    logic [71:0] rd72;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fifo_sync #(.DATAWIDTH(64), .ADDRWIDTH(5)) dut64 (
        .clk        (clk),
        .reset_l    (reset_l),
        .wr_data    (wr_data[63:0]),
        .we         (we),
        .full       (full64),
        .ns_rd_data (rd64),
        .re         (re),
        .ns_ne      (ne64)
    );

    fifo_sync #(.DATAWIDTH(72), .ADDRWIDTH(5)) dut72 (
        .clk        (clk),
        .reset_l    (reset_l),
        .wr_data    (wr_data),
        .we         (we),
        .full       (full72),
        .ns_rd_data (rd72),
        .re         (re),
        .ns_ne      (ne72)
    );

    // 72-bit word whose upper byte varies with the value, so lost top bits show up.
    function automatic logic [71:0] word(input logic [63:0] v);
        return {v[7:0] ^ 8'h5A, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_l = 1'b0; we = 1'b0; re = 1'b0; wr_data = '0;
        tick();
        reset_l = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (ne64 !== 1'b0 || ne72 !== 1'b0)
            $display("FAIL reset_ne: got %b/%b want 0", ne64, ne72);
        else n_pass++;
        n_checks++;
        if (full64 !== 1'b0 || full72 !== 1'b0)
            $display("FAIL reset_full: got %b/%b want 0", full64, full72);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [71:0] w;
        w = word(64'h1111_2222_3333_4444);
        wr_data = w; we = 1'b1;
        tick();
        we = 1'b0;
        n_checks++;
        if (ne64 !== 1'b1 || ne72 !== 1'b1)
            $display("FAIL single_ne: got %b/%b want 1", ne64, ne72);
        else n_pass++;
        n_checks++;
        if (rd64 !== w[63:0] || rd72 !== w)
            $display("FAIL single_data: got %h/%h want %h", rd64, rd72, w);
        else n_pass++;
        re = 1'b1;
        tick();
        re = 1'b0;
        n_checks++;
        if (ne64 !== 1'b0 || ne72 !== 1'b0)
            $display("FAIL single_pop_ne: got %b/%b want 0", ne64, ne72);
        else n_pass++;
    endtask

    task automatic test_fill();
        logic [71:0] w;
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (full64 !== 1'b0 || full72 !== 1'b0)
                $display("FAIL fill_notfull_%0d: got %b/%b want 0", i, full64, full72);
            else n_pass++;
            wr_data = word(64'(i)); we = 1'b1;
            tick();
        end
        n_checks++;
        if (full64 !== 1'b1 || full72 !== 1'b1)
            $display("FAIL fill_full: got %b/%b want 1", full64, full72);
        else n_pass++;
        wr_data = word(64'hDEAD);
        tick();
        we = 1'b0;
        n_checks++;
        if (full64 !== 1'b1 || full72 !== 1'b1)
            $display("FAIL overflow_full: got %b/%b want 1", full64, full72);
        else n_pass++;
        for (int i = 0; i < 32; i++) begin
            w = word(64'(i));
            n_checks++;
            if (ne64 !== 1'b1 || ne72 !== 1'b1 || rd64 !== w[63:0] || rd72 !== w)
                $display("FAIL drain_%0d: got ne %b/%b data %h/%h want %h",
                         i, ne64, ne72, rd64, rd72, w);
            else n_pass++;
            re = 1'b1;
            tick();
            re = 1'b0;
            if (i == 0) begin
                n_checks++;
                if (full64 !== 1'b0 || full72 !== 1'b0)
                    $display("FAIL drain_unfull: got %b/%b want 0", full64, full72);
                else n_pass++;
            end
        end
        n_checks++;
        if (ne64 !== 1'b0 || ne72 !== 1'b0)
            $display("FAIL drain_empty: got %b/%b want 0", ne64, ne72);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [71:0] w;
        for (int i = 0; i < 16; i++) begin
            wr_data = word(64'(100 + i)); we = 1'b1;
            tick();
        end
        re = 1'b1;
        for (int k = 0; k < 100; k++) begin
            w = word(64'(100 + k));
            n_checks++;
            if (ne64 !== 1'b1 || ne72 !== 1'b1 || full64 !== 1'b0 || full72 !== 1'b0 ||
                rd64 !== w[63:0] || rd72 !== w)
                $display("FAIL b2b_%0d: got ne %b/%b full %b/%b data %h/%h want %h",
                         k, ne64, ne72, full64, full72, rd64, rd72, w);
            else n_pass++;
            wr_data = word(64'(116 + k));
            tick();
        end
        we = 1'b0;
        for (int j = 0; j < 16; j++) begin
            w = word(64'(200 + j));
            n_checks++;
            if (ne64 !== 1'b1 || ne72 !== 1'b1 || rd64 !== w[63:0] || rd72 !== w)
                $display("FAIL b2b_drain_%0d: got ne %b/%b data %h/%h want %h",
                         j, ne64, ne72, rd64, rd72, w);
            else n_pass++;
            tick();
        end
        re = 1'b0;
        n_checks++;
        if (ne64 !== 1'b0 || ne72 !== 1'b0)
            $display("FAIL b2b_empty: got %b/%b want 0", ne64, ne72);
        else n_pass++;
    endtask

    task automatic test_empty_rw();
        logic [71:0] w;
        w = word(64'h55);
        wr_data = w; we = 1'b1; re = 1'b1;
        tick();
        we = 1'b0; re = 1'b0;
        n_checks++;
        if (ne64 !== 1'b1 || ne72 !== 1'b1 || rd64 !== w[63:0] || rd72 !== w)
            $display("FAIL empty_rw: got ne %b/%b data %h/%h want %h",
                     ne64, ne72, rd64, rd72, w);
        else n_pass++;
        re = 1'b1;
        tick();
        re = 1'b0;
        n_checks++;
        if (ne64 !== 1'b0 || ne72 !== 1'b0)
            $display("FAIL empty_rw_pop: got %b/%b want 0", ne64, ne72);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [71:0] w;
        for (int i = 0; i < 10; i++) begin
            wr_data = word(64'(300 + i)); we = 1'b1;
            tick();
        end
        reset_l = 1'b0; re = 1'b1; wr_data = word(64'hBAD);
        tick();
        reset_l = 1'b1; we = 1'b0; re = 1'b0;
        n_checks++;
        if (ne64 !== 1'b0 || ne72 !== 1'b0 || full64 !== 1'b0 || full72 !== 1'b0)
            $display("FAIL midreset: got ne %b/%b full %b/%b want 0",
                     ne64, ne72, full64, full72);
        else n_pass++;
        w = word(64'hA5);
        wr_data = w; we = 1'b1;
        tick();
        we = 1'b0;
        n_checks++;
        if (ne64 !== 1'b1 || ne72 !== 1'b1 || rd64 !== w[63:0] || rd72 !== w)
            $display("FAIL midreset_first: got ne %b/%b data %h/%h want %h",
                     ne64, ne72, rd64, rd72, w);
        else n_pass++;
        re = 1'b1;
        tick();
        re = 1'b0;
        n_checks++;
        if (ne64 !== 1'b0 || ne72 !== 1'b0)
            $display("FAIL midreset_pop: got %b/%b want 0", ne64, ne72);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_empty_rw();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

endmodule
